// File: rtl/iq_packer_pkg.sv
// Shared types and constants for the IQ frame packer.
// Optional frame header is enabled by defining PACKER_HEADER_EN.
package iq_packer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    DISCARD = 2'd2
  } pk_state_e;

  localparam logic [15:0] SYNC_WORD = 16'hA5C3;

`ifdef PACKER_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif

  function automatic int frame_words(input int num_chans);
    return num_chans + HDR_WORDS;
  endfunction

endpackage

// File: rtl/packer_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module packer_ram #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  aclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/iq_frame_packer.sv
// Packs IQ sample pairs into 32-bit words, admits/drops whole frames, streams them out on AXI4-Stream.
// Define PACKER_HEADER_EN to prepend a {SYNC_WORD, frame_cnt} header word to every frame.
module iq_frame_packer
  import iq_packer_pkg::*;
#(
  parameter int SAMP_WIDTH = 16,
  parameter int NUM_CHANS  = 13,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [SAMP_WIDTH-1:0]   in_data,
  input  logic                    in_vld,
  input  logic                    in_first,
  output logic [2*SAMP_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             sync_err_cnt,
  output logic [ADDR_WIDTH:0]     fill
);

  localparam int PW        = ADDR_WIDTH + 1;
  localparam int WW        = 2*SAMP_WIDTH + 1;
  localparam int LAST_SLOT = 2*NUM_CHANS - 1;
  localparam int SLOT_W    = $clog2(2*NUM_CHANS);
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] FW    = PW'(frame_words(NUM_CHANS));
  localparam logic [PW-1:0] HDR   = PW'(HDR_WORDS);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pk_state_e             state;
  logic [SLOT_W-1:0]     slot;
  logic [PW-1:0]         wr_ptr, cmt_ptr, rd_ptr, fch_ptr;
  logic [15:0]           frame_cnt;
  logic [SAMP_WIDTH-1:0] real_p0;
  logic [PW-1:0]         free;
  logic                  admit, last_slot;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WW-1:0]         wr_word, ram_q;
  logic                  ram_vld, fetch, out_load;

  assign free      = DEPTH - (cmt_ptr - rd_ptr);
  assign admit     = (free >= FW);
  assign last_slot = (slot == SLOT_W'(LAST_SLOT));
  assign fill      = cmt_ptr - rd_ptr;

  // Stage p0: hold the real sample until its imag partner arrives
  always_ff @(posedge aclk) begin
    if (in_vld) real_p0 <= in_data;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    wr_word = {1'b0, in_data, real_p0};
    if (in_vld && !in_first && state == ACCEPT && slot[0]) begin
      wr_en   = 1'b1;
      wr_word = {last_slot, in_data, real_p0};
    end
`ifdef PACKER_HEADER_EN
    // Header goes at the committed pointer: any partial frame is being rolled back
    if (in_vld && in_first && admit) begin
      wr_en   = 1'b1;
      wr_addr = cmt_ptr[ADDR_WIDTH-1:0];
      wr_word = WW'({1'b0, SYNC_WORD, frame_cnt});
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      slot         <= '0;
      wr_ptr       <= '0;
      cmt_ptr      <= '0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      sync_err_cnt <= '0;
    end else if (in_vld) begin
      if (in_first) begin
        if (state == ACCEPT) sync_err_cnt <= sat_inc(sync_err_cnt);
        slot <= SLOT_W'(1);
        if (admit) begin
          state  <= ACCEPT;
          wr_ptr <= cmt_ptr + HDR;
        end else begin
          state    <= DISCARD;
          wr_ptr   <= cmt_ptr;
          drop_cnt <= sat_inc(drop_cnt);
        end
      end else if (state != IDLE) begin
        if (last_slot) begin
          state <= IDLE;
          slot  <= '0;
          if (state == ACCEPT) begin
            wr_ptr    <= wr_ptr + PW'(1);
            cmt_ptr   <= wr_ptr + PW'(1);
            frame_cnt <= frame_cnt + 16'd1;
          end
        end else begin
          slot <= slot + SLOT_W'(1);
          if (state == ACCEPT && slot[0]) wr_ptr <= wr_ptr + PW'(1);
        end
      end
    end
  end

  packer_ram #(
    .WIDTH      (WW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .aclk  (aclk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_word),
    .re    (fetch),
    .raddr (fch_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

  // Stage p1/p2: RAM output register feeds the output register; only committed words are fetched
  assign out_load = ram_vld && (!m_axis_tvalid || m_axis_tready);
  assign fetch    = (fch_ptr != cmt_ptr) && (!ram_vld || out_load);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fch_ptr       <= '0;
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (fetch) fch_ptr <= fch_ptr + PW'(1);
      if (fetch) ram_vld <= 1'b1;
      else if (out_load) ram_vld <= 1'b0;
      if (out_load) begin
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tdata} <= ram_q;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// Self-checking bench for iq_frame_packer: directed tables, corner sequences, randomized traffic vs a frame-level model.
module tb_iq_frame_packer;
  import iq_packer_pkg::*;

  localparam int SW    = 16;
  localparam int NC    = 13;
  localparam int AW    = 6;
  localparam int DEPTH = 2**AW;
  localparam int FW    = frame_words(NC);
  localparam int NSLOT = 2*NC;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [SW-1:0] in_data = '0;
  logic          in_vld = 1'b0;
  logic          in_first = 1'b0;
  logic [2*SW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [15:0]   drop_cnt, sync_err_cnt;
  logic [AW:0]   fill;

  iq_frame_packer #(.SAMP_WIDTH(SW), .NUM_CHANS(NC), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset), .in_data(in_data), .in_vld(in_vld), .in_first(in_first),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .drop_cnt(drop_cnt), .sync_err_cnt(sync_err_cnt), .fill(fill)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = stalled, 1 = always ready, 2 = toggling, 3 = random
  int rdy_mode = 0;
  always @(negedge aclk) begin
    case (rdy_mode)
      0: m_axis_tready = 1'b0;
      1: m_axis_tready = 1'b1;
      2: m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Frame-level reference model
  logic [32:0] exp_q[$];
  logic [15:0] m_samp[$];
  int committed, consumed, m_drop, m_sync, m_fcnt, m_cnt;
  bit m_active, m_admit;
  int tlast_seen = 0;
  bit first_seen = 1'b0;
  logic [31:0] first_word = '0;

  task automatic model_sample(input logic [15:0] d, input bit f, input int occ);
    if (f) begin
      if (m_active && m_admit && m_sync < 65535) m_sync++;
      m_active = 1'b1;
      m_cnt = 1;
      m_samp.delete();
      m_samp.push_back(d);
      m_admit = (DEPTH - occ) >= FW;
      if (!m_admit && m_drop < 65535) m_drop++;
    end else if (m_active) begin
      m_samp.push_back(d);
      m_cnt++;
      if (m_cnt == NSLOT) begin
        if (m_admit) begin
          if (FW > NC) exp_q.push_back({1'b0, SYNC_WORD, 16'(m_fcnt)});
          for (int k = 0; k < NC; k++)
            exp_q.push_back({(k == NC-1), m_samp[2*k+1], m_samp[2*k]});
          committed += FW;
          m_fcnt++;
        end
        m_active = 1'b0;
      end
    end
  endtask

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      exp_q.delete();
      committed = 0; consumed = 0; m_drop = 0; m_sync = 0; m_fcnt = 0; m_cnt = 0;
      m_active = 1'b0; m_admit = 1'b0;
    end else begin
      int occ;
      occ = committed - consumed;
      check("fill", 64'(fill), 64'(occ));
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_tvalid", 64'(m_axis_tvalid), 64'(0));
        end else begin
          check("word", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q[0]));
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            consumed++;
            if (m_axis_tlast) tlast_seen++;
            if (!first_seen) begin
              first_word = m_axis_tdata;
              first_seen = 1'b1;
            end
          end
        end
      end
      if (in_vld) model_sample(in_data, in_first, occ);
    end
  end

  task automatic drive(input bit v, input bit f, input logic [15:0] d);
    in_vld = v; in_first = f; in_data = d;
    @(negedge aclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0);
  endtask

  task automatic send_slots(input int from, input int to, input bit seq_data);
    for (int s = from; s <= to; s++)
      drive(1'b1, (s == 0), seq_data ? 16'(s) : 16'($urandom));
  endtask

  task automatic do_reset();
    in_vld = 1'b0; in_first = 1'b0;
    areset = 1'b1;
    @(negedge aclk); @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic drain(input int mode);
    int n;
    n = 0;
    rdy_mode = mode;
    while ((fill != 0 || m_axis_tvalid) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    check("drain_done", {fill, m_axis_tvalid}, 64'(0));
    check("model_leftover", 64'(exp_q.size()), 64'(0));
    rdy_mode = 1;
  endtask

  typedef struct {
    int frames;
    int exp_fill;
    int exp_drop;
    int exp_lasts;
  } scen_t;

  scen_t tbl[4];

  initial begin
    tbl[0] = '{1, FW,   0, 1};
    tbl[1] = '{4, 4*FW, 0, 4};
    tbl[2] = '{5, 4*FW, 1, 4};
    tbl[3] = '{7, 4*FW, 3, 4};

    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    check("rst_sync", 64'(sync_err_cnt), 64'(0));
    check("rst_fill", 64'(fill), 64'(0));
    areset = 1'b0;
    @(negedge aclk);

    // Directed frame with slot n carrying value n, then a second one (frame_cnt 1)
    rdy_mode = 1;
    first_seen = 1'b0;
    tlast_seen = 0;
    send_slots(0, NSLOT-1, 1'b1);
    idle(2);
    drain(1);
    check("first_word", 64'(first_word), (FW > NC) ? 64'h0000_0000_A5C3_0000 : 64'h0000_0000_0001_0000);
    check("frame1_tlasts", 64'(tlast_seen), 64'(1));
    send_slots(0, NSLOT-1, 1'b1);
    idle(2);
    drain(1);

    // Back-to-back frames with the output stalled
    foreach (tbl[i]) begin
      rdy_mode = 0;
      do_reset();
      for (int f = 0; f < tbl[i].frames; f++) send_slots(0, NSLOT-1, 1'b0);
      idle(3);
      check("tbl_fill", 64'(fill), 64'(tbl[i].exp_fill));
      check("tbl_drop", 64'(drop_cnt), 64'(tbl[i].exp_drop));
      tlast_seen = 0;
      drain(1);
      check("tbl_tlasts", 64'(tlast_seen), 64'(tbl[i].exp_lasts));
    end

    // Early in_first at slot 10 aborts the frame in progress
    rdy_mode = 0;
    do_reset();
    send_slots(0, 9, 1'b0);
    drive(1'b1, 1'b1, 16'($urandom));
    check("abort_fill", 64'(fill), 64'(0));
    check("abort_sync", 64'(sync_err_cnt), 64'(1));
    send_slots(1, NSLOT-1, 1'b0);
    idle(3);
    check("abort_new_fill", 64'(fill), 64'(FW));
    tlast_seen = 0;
    drain(1);
    check("abort_tlasts", 64'(tlast_seen), 64'(1));
    check("abort_sync_model", 64'(sync_err_cnt), 64'(m_sync));

    // Toggling ready while frames stream out
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) send_slots(0, NSLOT-1, 1'b0);
    drain(2);

    // Randomized traffic: gaps, stray in_first, random restarts, random ready
    rdy_mode = 3;
    begin
      int rs;
      rs = 0;
      for (int c = 0; c < 1500; c++) begin
        bit v, f;
        v = ($urandom_range(0, 3) != 0);
        if (v && (rs == 0 || $urandom_range(0, 59) == 0)) begin
          f = 1'b1;
          rs = 1;
        end else begin
          f = v ? 1'b0 : 1'($urandom_range(0, 1));
          if (v) rs = (rs == NSLOT-1) ? 0 : rs + 1;
        end
        drive(v, f, 16'($urandom));
      end
    end
    send_slots(0, NSLOT-1, 1'b0);
    idle(2);
    check("rand_drop", 64'(drop_cnt), 64'(m_drop));
    check("rand_sync", 64'(sync_err_cnt), 64'(m_sync));
    drain(3);

    // Asynchronous reset mid-frame with two frames committed
    rdy_mode = 0;
    do_reset();
    send_slots(0, NSLOT-1, 1'b0);
    send_slots(0, NSLOT-1, 1'b0);
    send_slots(0, 6, 1'b0);
    check("prerst_tvalid", 64'(m_axis_tvalid), 64'(1));
    in_vld = 1'b1; in_first = 1'b0; in_data = 16'h0007;
    #1 areset = 1'b1;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("arst_tdata", 64'(m_axis_tdata), 64'(0));
    check("arst_tlast", 64'(m_axis_tlast), 64'(0));
    check("arst_fill", 64'(fill), 64'(0));
    check("arst_drop", 64'(drop_cnt), 64'(0));
    in_vld = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    rdy_mode = 1;
    first_seen = 1'b0;
    send_slots(0, NSLOT-1, 1'b1);
    idle(2);
    drain(1);
    check("post_rst_first", 64'(first_word), (FW > NC) ? 64'h0000_0000_A5C3_0000 : 64'h0000_0000_0001_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
